// File: rtl/imm_gen_ctrl_pkg.sv
// Shared definitions for the decode-stage immediate generator.
// Contents: opcode constants, FSM state encoding, immediate-class encoding and the
// opcode -> immediate-class decode function.
package imm_gen_ctrl_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned PAYLOAD_W = OP_W + IMM_W;

    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_LLB = 4'b1010;
    localparam logic [3:0] OP_LHB = 4'b1011;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        StRun       = 2'b00,
        StHaltDrain = 2'b01,
        StHalted    = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        ImmZero   = 3'd0,
        ImmMem    = 3'd1,
        ImmShamt  = 3'd2,
        ImmLlb    = 3'd3,
        ImmLhb    = 3'd4,
        ImmBranch = 3'd5,
        ImmPcs    = 3'd6
    } imm_class_e;

    function automatic imm_class_e imm_class(input logic [3:0] op);
        imm_class_e cls;
        case (op)
            OP_LW, OP_SW:           cls = ImmMem;
            OP_SLL, OP_SRA, OP_ROR: cls = ImmShamt;
            OP_LLB:                 cls = ImmLlb;
            OP_LHB:                 cls = ImmLhb;
            OP_B:                   cls = ImmBranch;
            OP_PCS:                 cls = ImmPcs;
            default:                cls = ImmZero;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/imm_gen_ctrl_if.sv
// Handshake bundle between IF/ID, the immediate generator and ID/EX.
// slave  : the immediate generator (consumes instructions, produces immediates)
// master : the surrounding pipeline (or a testbench)
// Signals: in_vld/in_rdy/instr_in (fetch side), out_vld/out_rdy/imm_out/op_out (execute
// side), flush (mispredict squash), halted (HLT drained).
interface imm_gen_ctrl_if;
    import imm_gen_ctrl_pkg::*;

    logic                 in_vld;
    logic                 in_rdy;
    logic [INSTR_W-1:0]   instr_in;
    logic                 flush;
    logic                 out_vld;
    logic                 out_rdy;
    logic [IMM_W-1:0]     imm_out;
    logic [OP_W-1:0]      op_out;
    logic                 halted;

    modport slave (
        input  in_vld, instr_in, flush, out_rdy,
        output in_rdy, out_vld, imm_out, op_out, halted
    );

    modport master (
        output in_vld, instr_in, flush, out_rdy,
        input  in_rdy, out_vld, imm_out, op_out, halted
    );

endinterface

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready output buffer (main + skid) with flush.
// Ports: clk, rst_n (sync, active low), flush (drop both entries and same-cycle input),
//        in_vld/in_rdy/in_data (write side), out_vld/out_rdy/out_data (read side, = main).
// in_rdy depends only on skid occupancy, so it never combinationally follows out_rdy.
module imm_skid_buf #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
);

    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             push;
    logic             pop;

    assign in_rdy   = ~skid_vld_q;
    assign out_vld  = main_vld_q;
    assign out_data = main_data_q;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        push        = in_vld & ~skid_vld_q;
        pop         = main_vld_q & out_rdy;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop) begin
            if (skid_vld_q) begin
                // Skid promotes into main; push is impossible since in_rdy is low.
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
            end else begin
                main_vld_d = push;
                if (push) begin
                    main_data_d = in_data;
                end
            end
        end else if (push) begin
            if (!main_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = in_data;
            end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: rtl/sext_12to16.sv
// Sign-extends a 12-bit field to 16 bits.
// Ports: a (12-bit field), y (16-bit sign-extended result).
module sext_12to16 (
    input  logic [11:0] a,
    output logic [15:0] y
);
    assign y = {{4{a[11]}}, a};
endmodule

// File: rtl/sext_4to16.sv
// Sign-extends a 4-bit field to 16 bits.
// Ports: a (4-bit field), y (16-bit sign-extended result).
module sext_4to16 (
    input  logic [3:0]  a,
    output logic [15:0] y
);
    assign y = {{12{a[3]}}, a};
endmodule

// File: rtl/sext_9to16.sv
// Sign-extends a 9-bit field to 16 bits.
// Ports: a (9-bit field), y (16-bit sign-extended result).
module sext_9to16 (
    input  logic [8:0]  a,
    output logic [15:0] y
);
    assign y = {{7{a[8]}}, a};
endmodule

// File: rtl/imm_gen_ctrl.sv
// Decode-stage immediate generator/controller.
// Classifies each accepted 16-bit instruction by opcode, forms its 16-bit immediate and
// buffers {op, imm} toward ID/EX through a 2-entry skid buffer. Owns halt sequencing
// (RUN -> HALT_DRAIN -> HALTED) and flush.
// Ports: clk, rst_n (sync, active low), bus (imm_gen_ctrl_if.slave: in_vld, in_rdy,
//        instr_in, flush, out_vld, out_rdy, imm_out, op_out, halted).
module imm_gen_ctrl
    import imm_gen_ctrl_pkg::*;
#(
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_ctrl_if.slave  bus
);

    if (SKID_DEPTH != 2) begin : g_bad_depth
        $error("imm_gen_ctrl supports only SKID_DEPTH == 2");
    end

    state_e               state_q, state_d;
    logic [OP_W-1:0]      op;
    imm_class_e           cls;
    logic [15:0]          s4, s9, s12;
    logic [IMM_W-1:0]     imm;
    logic                 buf_in_vld, buf_in_rdy, buf_out_vld;
    logic [PAYLOAD_W-1:0] buf_out_data;
    logic                 run;
    logic                 accept;
    logic                 consume;

    assign op  = bus.instr_in[15:12];
    assign cls = imm_class(op);

    sext_4to16 u_sext4 (
        .a (bus.instr_in[3:0]),
        .y (s4)
    );

    sext_9to16 u_sext9 (
        .a (bus.instr_in[8:0]),
        .y (s9)
    );

    sext_12to16 u_sext12 (
        .a (bus.instr_in[11:0]),
        .y (s12)
    );

    // Word-offset forms shift left by one; the extended MSB simply falls off.
    always_comb begin
        imm = '0;
        case (cls)
            ImmMem:    imm = {s4[14:0], 1'b0};
            ImmShamt:  imm = {12'h000, bus.instr_in[3:0]};
            ImmLlb:    imm = {8'h00, bus.instr_in[7:0]};
            ImmLhb:    imm = {bus.instr_in[7:0], 8'h00};
            ImmBranch: imm = {s9[14:0], 1'b0};
            ImmPcs:    imm = s12;
            default:   imm = '0;
        endcase
    end

    assign run        = (state_q == StRun);
    // rst_n gates in_rdy so nothing is offered as accepted during the reset cycle.
    assign bus.in_rdy = rst_n & run & buf_in_rdy;
    assign buf_in_vld = bus.in_vld & rst_n & run;

    imm_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .in_vld   (buf_in_vld),
        .in_rdy   (buf_in_rdy),
        .in_data  ({op, imm}),
        .out_vld  (buf_out_vld),
        .out_rdy  (bus.out_rdy),
        .out_data (buf_out_data)
    );

    assign bus.out_vld = buf_out_vld & (state_q != StHalted);
    assign bus.op_out  = buf_out_data[PAYLOAD_W-1:IMM_W];
    assign bus.imm_out = buf_out_data[IMM_W-1:0];
    assign bus.halted  = (state_q == StHalted);

    assign accept  = bus.in_vld & bus.in_rdy & ~bus.flush;
    assign consume = bus.out_vld & bus.out_rdy & ~bus.flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (accept && op == OP_HLT) begin
                    state_d = StHaltDrain;
                end
            end
            StHaltDrain: begin
                // Flush squashes the buffered HLT, so execution resumes.
                if (bus.flush) begin
                    state_d = StRun;
                end else if (consume && bus.op_out == OP_HLT) begin
                    state_d = StHalted;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
